// File: rtl/regfile_bist.sv
// March-style self test for a 2-read/1-write register file: writes a pattern and
// reads it back pairwise, then repeats with the inverted pattern.
module regfile_bist #(
   parameter int ADDR_W = 5,
   parameter int XLEN   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [XLEN-1:0]   fail_data,
   output logic              we3,
   output logic [ADDR_W-1:0] wa3,
   output logic [XLEN-1:0]   wd3,
   output logic [ADDR_W-1:0] ra1,
   output logic [ADDR_W-1:0] ra2,
   input  logic [XLEN-1:0]   rd1,
   input  logic [XLEN-1:0]   rd2
);

   typedef enum logic [1:0] {IDLE, WRITE, READ, FINISH} state_t;

   localparam logic [ADDR_W-1:0] LAST = '1;

   state_t              state_q, state_d;
   logic                pidx_q, pidx_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   addr_nxt;
   logic                pass_d;
   logic [ADDR_W-1:0]   fail_addr_d;
   logic [XLEN-1:0]     fail_data_d;

   // Pass 0 writes 2*a, pass 1 its complement, so every bit is seen at both levels.
   function automatic logic [XLEN-1:0] pattern(input logic p, input logic [ADDR_W-1:0] a);
      logic [XLEN-1:0] v;
      v = XLEN'({a, 1'b0});
      return p ? ~v : v;
   endfunction

   // Register x0 is hardwired to zero, so it never reads back the pattern.
   function automatic logic [XLEN-1:0] expected(input logic p, input logic [ADDR_W-1:0] a);
      return (a == '0) ? '0 : pattern(p, a);
   endfunction

   assign addr_nxt = addr_q + ADDR_W'(1);

   // NOTE: every output and next-state signal gets a default before the case so the
   // combinational block cannot infer latches; blocking '=' is correct here.
   always_comb begin
      state_d     = state_q;
      pidx_d      = pidx_q;
      addr_d      = addr_q;
      pass_d      = pass;
      fail_addr_d = fail_addr;
      fail_data_d = fail_data;
      busy        = (state_q != IDLE);
      done        = (state_q == FINISH);
      we3         = 1'b0;
      wa3         = '0;
      wd3         = '0;
      ra1         = '0;
      ra2         = '0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = WRITE;
               pidx_d      = 1'b0;
               addr_d      = '0;
               pass_d      = 1'b0;
               fail_addr_d = '0;
               fail_data_d = '0;
            end
         end
         WRITE: begin
            we3    = 1'b1;
            wa3    = addr_q;
            wd3    = pattern(pidx_q, addr_q);
            addr_d = addr_nxt;
            if (addr_q == LAST) state_d = READ;
         end
         READ: begin
            ra1 = addr_q;
            ra2 = addr_nxt;
            if (rd1 != expected(pidx_q, addr_q)) begin
               fail_addr_d = addr_q;
               fail_data_d = rd1;
               pass_d      = 1'b0;
               state_d     = FINISH;
            end else if (rd2 != expected(pidx_q, addr_nxt)) begin
               fail_addr_d = addr_nxt;
               fail_data_d = rd2;
               pass_d      = 1'b0;
               state_d     = FINISH;
            end else begin
               addr_d = addr_nxt;
               if (addr_q == LAST) begin
                  if (!pidx_q) begin
                     pidx_d  = 1'b1;
                     state_d = WRITE;
                  end else begin
                     pass_d  = 1'b1;
                     state_d = FINISH;
                  end
               end
            end
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking '<=' so all flops update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         pidx_q    <= 1'b0;
         addr_q    <= '0;
         pass      <= 1'b0;
         fail_addr <= '0;
         fail_data <= '0;
      end else begin
         state_q   <= state_d;
         pidx_q    <= pidx_d;
         addr_q    <= addr_d;
         pass      <= pass_d;
         fail_addr <= fail_addr_d;
         fail_data <= fail_data_d;
      end
   end

endmodule

// File: tb/tb_regfile_bist.sv
// Bench for regfile_bist: behavioural register file with injectable faults, a
// cycle-index model of the test run, and directed scenarios.
module tb_regfile_bist;

   localparam int AW = 5;
   localparam int XL = 32;
   localparam int N  = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          busy, done, pass, we3;
   logic [AW-1:0] fail_addr, wa3, ra1, ra2;
   logic [XL-1:0] fail_data, wd3, rd1, rd2;

   // 0 = healthy, 1 = reg 7 bit 3 stuck at 0, 2 = reg 0 not hardwired
   int            mode = 0;
   logic [XL-1:0] regs [N];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   regfile_bist #(.ADDR_W(AW), .XLEN(XL)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
      .fail_addr(fail_addr), .fail_data(fail_data), .we3(we3), .wa3(wa3), .wd3(wd3),
      .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2)
   );

   function automatic logic [XL-1:0] apply_fault(input int a, input logic [XL-1:0] stored);
      logic [XL-1:0] v;
      v = stored;
      if (a == 0 && mode != 2) v = '0;
      if (mode == 1 && a == 7) v[3] = 1'b0;
      return v;
   endfunction

   always @(posedge clk) if (we3) regs[wa3] <= wd3;
   assign rd1 = apply_fault(int'(ra1), regs[ra1]);
   assign rd2 = apply_fault(int'(ra2), regs[ra2]);

   function automatic logic [XL-1:0] pat(input int p, input int a);
      logic [XL-1:0] v;
      v = XL'(2 * a);
      return (p == 1) ? ~v : v;
   endfunction

   function automatic logic [XL-1:0] exp_val(input int p, input int a);
      return (a == 0) ? '0 : pat(p, a);
   endfunction

   function automatic logic [XL-1:0] mread(input int p, input int a);
      return apply_fault(a, pat(p, a));
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Model: a run is 128 cycles indexed by k; quarter k/32 selects write/read and pass.
   bit            m_run = 0, m_fin = 0, m_pass = 0;
   int            m_k = 0, m_fa = 0;
   logic [XL-1:0] m_fd = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_run <= 0; m_fin <= 0; m_pass <= 0; m_k <= 0; m_fa <= 0; m_fd <= '0;
      end else if (m_fin) begin
         m_fin <= 0;
      end else if (!m_run) begin
         if (start) begin
            m_run <= 1; m_k <= 0; m_pass <= 0; m_fa <= 0; m_fd <= '0;
         end
      end else if ((m_k / N) % 2 == 1 &&
                   mread(m_k / 64, m_k % N) != exp_val(m_k / 64, m_k % N)) begin
         m_fa <= m_k % N; m_fd <= mread(m_k / 64, m_k % N); m_run <= 0; m_fin <= 1;
      end else if ((m_k / N) % 2 == 1 &&
                   mread(m_k / 64, (m_k + 1) % N) != exp_val(m_k / 64, (m_k + 1) % N)) begin
         m_fa <= (m_k + 1) % N; m_fd <= mread(m_k / 64, (m_k + 1) % N); m_run <= 0; m_fin <= 1;
      end else if (m_k == 4 * N - 1) begin
         m_pass <= 1; m_run <= 0; m_fin <= 1;
      end else begin
         m_k <= m_k + 1;
      end
   end

   always @(negedge clk) begin
      bit e_w, e_r;
      int a, p;
      e_w = m_run && ((m_k / N) % 2 == 0);
      e_r = m_run && ((m_k / N) % 2 == 1);
      a   = m_k % N;
      p   = m_k / 64;
      check("busy", 64'(busy), 64'(m_run || m_fin));
      check("done", 64'(done), 64'(m_fin));
      check("pass", 64'(pass), 64'(m_pass));
      check("fail_addr", 64'(fail_addr), 64'(m_fa));
      check("fail_data", 64'(fail_data), 64'(m_fd));
      check("we3", 64'(we3), 64'(e_w));
      check("wa3", 64'(wa3), e_w ? 64'(a) : 64'(0));
      check("wd3", 64'(wd3), e_w ? 64'(pat(p, a)) : 64'(0));
      check("ra1", 64'(ra1), e_r ? 64'(a) : 64'(0));
      check("ra2", 64'(ra2), e_r ? 64'((a + 1) % N) : 64'(0));
   end

   // Raise start across one rising edge; returns at the first falling edge of the run.
   task automatic launch();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
   endtask

   // Steps falling edges from the run's first cycle until busy drops, asserting
   // start on the listed cycle indices.
   task automatic run_measure(input int p1, input int p2, input int p3,
                              output int busy_n, output int done_n);
      int n;
      busy_n = 0;
      done_n = -1;
      for (n = 0; n < 300; n++) begin
         start = (n == p1 || n == p2 || n == p3);
         if (busy) busy_n++;
         if (done) done_n = n;
         if (!busy && n > 0) break;
         @(negedge clk);
      end
      check("run_bound", 64'(n < 300), 64'(1));
   endtask

   initial begin
      int b, d, guard;
      start = 1'b0;
      rst   = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_pass", 64'(pass), 64'(0));
      check("rst_we3", 64'(we3), 64'(0));
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // healthy run
      launch();
      run_measure(-1, -1, -1, b, d);
      check("healthy_busy_cycles", 64'(b), 64'(129));
      check("healthy_done_cycle", 64'(d), 64'(128));
      check("healthy_pass", 64'(pass), 64'(1));

      // reg 7 bit 3 stuck at 0: caught on ra2 at a=6 in pass 0
      mode = 1;
      launch();
      run_measure(-1, -1, -1, b, d);
      check("stuck_done_cycle", 64'(d), 64'(39));
      check("stuck_fail_addr", 64'(fail_addr), 64'(7));
      check("stuck_fail_data", 64'(fail_data), 64'h6);
      check("stuck_pass", 64'(pass), 64'(0));

      // reg 0 writable: caught on ra1 at a=0 in pass 1
      mode = 2;
      launch();
      run_measure(-1, -1, -1, b, d);
      check("x0_done_cycle", 64'(d), 64'(97));
      check("x0_fail_addr", 64'(fail_addr), 64'(0));
      check("x0_fail_data", 64'(fail_data), 64'hFFFF_FFFF);
      check("x0_pass", 64'(pass), 64'(0));

      // reset in the middle of the first write sweep
      mode = 0;
      launch();
      start = 1'b0;
      guard = 0;
      while (!(we3 && wa3 == AW'(10)) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("reach_a10", 64'(guard < 50), 64'(1));
      #2 rst = 1'b1;
      #1;
      check("async_we3", 64'(we3), 64'(0));
      check("async_busy", 64'(busy), 64'(0));
      check("async_wa3", 64'(wa3), 64'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("no_resume", 64'(busy), 64'(0));
      end
      launch();
      run_measure(-1, -1, -1, b, d);
      check("post_rst_busy_cycles", 64'(b), 64'(129));
      check("post_rst_done_cycle", 64'(d), 64'(128));
      check("post_rst_pass", 64'(pass), 64'(1));

      // start while busy and in the done cycle is ignored; held into IDLE relaunches
      launch();
      run_measure(5, 128, 129, b, d);
      check("ignore_busy_cycles", 64'(b), 64'(129));
      check("ignore_done_cycle", 64'(d), 64'(128));
      check("idle_pass_held", 64'(pass), 64'(1));
      @(negedge clk);
      start = 1'b0;
      check("relaunch_busy", 64'(busy), 64'(1));
      check("relaunch_pass_clr", 64'(pass), 64'(0));
      run_measure(-1, -1, -1, b, d);
      check("relaunch_busy_cycles", 64'(b), 64'(129));
      check("relaunch_pass", 64'(pass), 64'(1));

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_bist.md
REGFILE_BIST -- requirements
Module: regfile_bist

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-002 SHALL have parameter XLEN, default 32, register data width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request one test run; sampled only in IDLE.
REQ-006 SHALL have port busy  output  1  high while a run is in progress.
REQ-007 SHALL have port done  output  1  one-cycle pulse at run end.
REQ-008 SHALL have port pass  output  1  result of last completed run, held until the next accepted start.
REQ-009 SHALL have port fail_addr  output  ADDR_W  register address of the first mismatch.
REQ-010 SHALL have port fail_data  output  XLEN  data read at the first mismatch.
REQ-011 SHALL have port we3  output  1  register-file write enable.
REQ-012 SHALL have port wa3  output  ADDR_W  register-file write address.
REQ-013 SHALL have port wd3  output  XLEN  register-file write data.
REQ-014 SHALL have ports ra1, ra2  output  ADDR_W  register-file read addresses.
REQ-015 SHALL have ports rd1, rd2  input  XLEN  register-file read data, combinational from ra1/ra2.

Function
REQ-016 SHALL implement FSM states IDLE, WRITE, READ, FINISH; pass index p in {0,1}; address counter a of ADDR_W bits.
REQ-017 SHALL define pattern(p,a) = zero-extended (a<<1) when p=0, bitwise inverse of that when p=1.
REQ-018 SHALL define expected(p,a) = 0 when a=0 (x0 hardwired), else pattern(p,a).
REQ-019 IDLE: start=1 at a clock edge -> WRITE with p=0, a=0, pass cleared to 0, fail_addr/fail_data cleared to 0; busy=1 from the next cycle.
REQ-020 WRITE: we3=1, wa3=a, wd3=pattern(p,a); a increments each cycle; after a=2**ADDR_W-1 -> READ with a=0.
REQ-021 READ: we3=0, ra1=a, ra2=a+1 modulo 2**ADDR_W (wraps to 0); rd1 compared with expected(p,a), rd2 compared with expected(p,a+1) in the same cycle.
REQ-022 A READ mismatch SHALL capture fail_addr/fail_data from the ra1 port if it mismatches, else from ra2, then go to FINISH with pass=0; no further reads are performed.
REQ-023 READ with a=2**ADDR_W-1 and no mismatch: p=0 -> WRITE with p=1, a=0; p=1 -> FINISH with pass=1.
REQ-024 FINISH SHALL last one cycle with done=1 and busy=1, then return to IDLE with busy=0.
REQ-025 A fault-free run SHALL take exactly 4*2**ADDR_W cycles from the start edge to the done cycle, plus the one FINISH cycle.
REQ-026 start while busy SHALL be ignored; start held high in IDLE SHALL launch a new run on each IDLE edge.
REQ-027 Outside WRITE, we3 SHALL be 0; outside READ, ra1=ra2=0; wa3 and wd3 SHALL be 0 when we3=0.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, p=0, a=0, busy=0, done=0, pass=0, fail_addr=0, fail_data=0, we3=0, and all address/data outputs to 0, including mid-run.
REQ-029 After rst deasserts, the block SHALL wait in IDLE for start; a partial run SHALL NOT resume.

Verification (ADDR_W=5, XLEN=32, connected to register_file)
REQ-030 Healthy register file, start pulse -> busy for 129 cycles, done at cycle 128 after start, pass=1.
REQ-031 Bit 3 of register 7 stuck at 0 -> pass-0 READ at a=6 flags the ra2 port: fail_addr=7, fail_data=0x00000006, pass=0, done in the cycle after the mismatch.
REQ-032 Register 0 writable (no hardwiring) -> pass-1 READ at a=0 flags ra1: fail_addr=0, fail_data=0xFFFFFFFF, pass=0.
REQ-033 rst asserted during WRITE at a=10 -> we3=0 and busy=0 asynchronously; a new start gives a full 128-cycle run and pass=1.
REQ-034 start pulsed while busy, and again in the done cycle -> both ignored; start in the following IDLE cycle launches a run and clears pass to 0.
